// File: rtl/z80_cmd_mailbox.sv
// z80_cmd_mailbox: 68k->Z80 command FIFO with NMI sequencing, status/reply ports and YM2610 strobe decode.
// Build option: define Z80CTRL_NMI_AUTOREARM_EN to re-assert NMI after the gap while commands remain queued.
module z80_cmd_mailbox #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int NMI_GAP     = 6
) (
    input  logic                          CLK_24M,
    input  logic                          nRESET,
    input  logic [7:0]                    SDA_L,
    input  logic [7:0]                    SDD_IN,
    output logic [7:0]                    SDD_OUT,
    input  logic                          nIORQ,
    input  logic                          nSDRD,
    input  logic                          nSDWR,
    input  logic                          CMD_WR,
    input  logic [7:0]                    CMD_DATA,
    output logic [7:0]                    REPLY,
    output logic [$clog2(FIFO_DEPTH):0]   CMD_LEVEL,
    output logic                          CMD_FULL,
    output logic                          nZ80NMI,
    output logic                          n2610RD,
    output logic                          n2610WR,
    output logic                          n2610CS
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int GW = $clog2(NMI_GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } nmi_state_t;

    logic                   io_rd_n_s, io_wr_n_s;
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d;
    logic                   rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
    logic                   rd_arm_q, rd_arm_d, wr_arm_q, wr_arm_d;
    logic                   rd_rise_s, rd_fall_s, wr_rise_s, wr_fall_s;
    logic                   rd_done_s, wr_done_s;
    logic [2:0]             addr_q, addr_d;
    logic [7:0]             data_q, data_d;

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [7:0]             mem_d [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             last_pop_q, last_pop_d;
    logic [7:0]             reply_q, reply_d;
    logic                   en_q, en_d;

    nmi_state_t             state_q, state_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic                   push_seen_q, push_seen_d;
    logic                   nmi_n_q, nmi_n_d;

    logic                   full_s, empty_s, push_s, pop_s, ovf_set_s, stat_clr_s;
    logic                   rel_s, en_wr_s, reply_wr_s, gap_done_s;
    logic [1:0]             grp_s;
    logic [LW+3:0]          lvl_ext_s;
    logic [7:0]             status_s, sdd_out_s;

    assign io_rd_n_s = nIORQ | nSDRD;
    assign io_wr_n_s = nIORQ | nSDWR;

    // Strobe synchronisers with armed edge detection and access address/data capture.
    // Sync flops reset to the active level so an access straddling reset release never arms.
    always_comb begin
        rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], io_rd_n_s};
        wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], io_wr_n_s};
        rd_prev_d = rd_sync_q[SYNC_STAGES-1];
        wr_prev_d = wr_sync_q[SYNC_STAGES-1];
        rd_rise_s = rd_sync_q[SYNC_STAGES-1] & ~rd_prev_q;
        rd_fall_s = ~rd_sync_q[SYNC_STAGES-1] & rd_prev_q;
        wr_rise_s = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
        wr_fall_s = ~wr_sync_q[SYNC_STAGES-1] & wr_prev_q;
        if (rd_fall_s) begin
            rd_arm_d = 1'b1;
        end else if (rd_rise_s) begin
            rd_arm_d = 1'b0;
        end else begin
            rd_arm_d = rd_arm_q;
        end
        if (wr_fall_s) begin
            wr_arm_d = 1'b1;
        end else if (wr_rise_s) begin
            wr_arm_d = 1'b0;
        end else begin
            wr_arm_d = wr_arm_q;
        end
        rd_done_s = rd_rise_s & rd_arm_q;
        wr_done_s = wr_rise_s & wr_arm_q;
        if (!io_rd_n_s || !io_wr_n_s) begin
            addr_d = SDA_L[4:2];
            data_d = SDD_IN;
        end else begin
            addr_d = addr_q;
            data_d = data_q;
        end
    end

    // Command FIFO, overflow flag, reply latch and NMI enable.
    always_comb begin
        grp_s      = addr_q[1:0];
        full_s     = (level_q == LW'(FIFO_DEPTH));
        empty_s    = (level_q == {LW{1'b0}});
        pop_s      = rd_done_s && (grp_s == 2'b00) && !empty_s;
        push_s     = CMD_WR && (!full_s || pop_s);
        ovf_set_s  = CMD_WR && full_s && !pop_s;
        stat_clr_s = rd_done_s && (grp_s == 2'b10);
        rel_s      = wr_done_s && (grp_s == 2'b00);
        en_wr_s    = wr_done_s && (grp_s == 2'b10);
        reply_wr_s = wr_done_s && (grp_s == 2'b11);

        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = CMD_DATA;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            last_pop_d = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d   = rd_ptr_q;
            last_pop_d = last_pop_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A drop in the same cycle as a status read must not be lost.
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (stat_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        reply_d     = reply_wr_s ? data_q : reply_q;
        en_d        = en_wr_s ? addr_q[2] : en_q;
        push_seen_d = push_s;
    end

    // NMI sequencer next-state logic.
    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        gap_done_s = (gap_cnt_q == GW'(NMI_GAP - 1));
        if (!en_q) begin
            state_d   = ST_IDLE;
            gap_cnt_d = {GW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (push_seen_q) begin
                        state_d = ST_ASSERT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ASSERT: begin
                    if (pop_s || rel_s) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = {GW{1'b0}};
                    end else begin
                        state_d   = ST_ASSERT;
                    end
                end
                ST_GAP: begin
                    if (rel_s) begin
                        gap_cnt_d = {GW{1'b0}};
                    end else if (gap_done_s) begin
                        gap_cnt_d = {GW{1'b0}};
`ifdef Z80CTRL_NMI_AUTOREARM_EN
                        state_d   = (level_d != {LW{1'b0}}) ? ST_ASSERT : ST_IDLE;
`else
                        state_d   = ST_IDLE;
`endif
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = {GW{1'b0}};
                end
            endcase
        end
        nmi_n_d = (state_d != ST_ASSERT);
    end

    // State registers.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            rd_sync_q   <= {SYNC_STAGES{1'b0}};
            wr_sync_q   <= {SYNC_STAGES{1'b0}};
            rd_prev_q   <= 1'b0;
            wr_prev_q   <= 1'b0;
            rd_arm_q    <= 1'b0;
            wr_arm_q    <= 1'b0;
            addr_q      <= 3'b000;
            data_q      <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            level_q     <= {LW{1'b0}};
            ovf_q       <= 1'b0;
            last_pop_q  <= 8'h00;
            reply_q     <= 8'h00;
            en_q        <= 1'b0;
            state_q     <= ST_IDLE;
            gap_cnt_q   <= {GW{1'b0}};
            push_seen_q <= 1'b0;
            nmi_n_q     <= 1'b1;
        end else begin
            rd_sync_q   <= rd_sync_d;
            wr_sync_q   <= wr_sync_d;
            rd_prev_q   <= rd_prev_d;
            wr_prev_q   <= wr_prev_d;
            rd_arm_q    <= rd_arm_d;
            wr_arm_q    <= wr_arm_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            last_pop_q  <= last_pop_d;
            reply_q     <= reply_d;
            en_q        <= en_d;
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            push_seen_q <= push_seen_d;
            nmi_n_q     <= nmi_n_d;
        end
    end

    // Z80 read-data mux and YM2610 strobes, decoded straight from the live bus.
    always_comb begin
        lvl_ext_s = {4'b0000, level_q};
        status_s  = {ovf_q, empty_s, full_s, 1'b0, lvl_ext_s[3:0]};
        sdd_out_s = 8'h00;
        if (!io_rd_n_s) begin
            case (SDA_L[3:2])
                2'b00:   sdd_out_s = empty_s ? last_pop_q : mem_q[rd_ptr_q];
                2'b10:   sdd_out_s = status_s;
                2'b11:   sdd_out_s = reply_q;
                default: sdd_out_s = 8'h00;
            endcase
        end else begin
            sdd_out_s = 8'h00;
        end
    end

    assign SDD_OUT   = sdd_out_s;
    assign n2610RD   = !(!io_rd_n_s && (SDA_L[3:2] == 2'b01));
    assign n2610WR   = !(!io_wr_n_s && (SDA_L[3:2] == 2'b01));
    assign n2610CS   = n2610RD & n2610WR;
    assign REPLY     = reply_q;
    assign CMD_LEVEL = level_q;
    assign CMD_FULL  = full_s;
    assign nZ80NMI   = nmi_n_q;

endmodule

// File: tb/tb_z80_cmd_mailbox.sv
// Directed bench for z80_cmd_mailbox: table of FIFO/status/reply vectors plus hand sequences
// for NMI timing, same-cycle push/pop, YM strobes and reset during an access.
module tb_z80_cmd_mailbox;

    localparam int SYNC = 2;
    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_ZRD  = 2'd1;
    localparam logic [1:0] OP_ZWR  = 2'd2;

    logic       CLK_24M = 1'b0;
    logic       nRESET;
    logic [7:0] SDA_L, SDD_IN, SDD_OUT, CMD_DATA, REPLY;
    logic       nIORQ, nSDRD, nSDWR, CMD_WR, CMD_FULL, nZ80NMI;
    logic       n2610RD, n2610WR, n2610CS;
    logic [2:0] CMD_LEVEL;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int hi_run  = 0;
    int gap_log [64];

    z80_cmd_mailbox dut (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .SDA_L(SDA_L), .SDD_IN(SDD_IN),
        .SDD_OUT(SDD_OUT), .nIORQ(nIORQ), .nSDRD(nSDRD), .nSDWR(nSDWR),
        .CMD_WR(CMD_WR), .CMD_DATA(CMD_DATA), .REPLY(REPLY), .CMD_LEVEL(CMD_LEVEL),
        .CMD_FULL(CMD_FULL), .nZ80NMI(nZ80NMI), .n2610RD(n2610RD),
        .n2610WR(n2610WR), .n2610CS(n2610CS)
    );

    always #5 CLK_24M = ~CLK_24M;

    // NMI pulse counter; gap_log[p] holds the high run preceding pulse p.
    always @(negedge CLK_24M) begin
        if (nZ80NMI === 1'b0) begin
            if (hi_run > 0) begin
                gap_log[pulses % 64] <= hi_run;
                pulses <= pulses + 1;
            end
            hi_run <= 0;
        end else begin
            hi_run <= hi_run + 1;
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic [2:0] exp_lvl;
        logic       exp_full;
        logic [7:0] exp_reply;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge CLK_24M);
        CMD_WR = 1'b1;
        CMD_DATA = d;
        @(negedge CLK_24M);
        CMD_WR = 1'b0;
    endtask

    task automatic z80_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge CLK_24M);
        SDA_L = a;
        nIORQ = 1'b0;
        nSDRD = 1'b0;
        repeat (3) @(negedge CLK_24M);
        d = SDD_OUT;
        nIORQ = 1'b1;
        nSDRD = 1'b1;
        repeat (4) @(negedge CLK_24M);
    endtask

    task automatic z80_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK_24M);
        SDA_L = a;
        SDD_IN = d;
        nIORQ = 1'b0;
        nSDWR = 1'b0;
        repeat (3) @(negedge CLK_24M);
        nIORQ = 1'b1;
        nSDWR = 1'b1;
        repeat (4) @(negedge CLK_24M);
    endtask

    task automatic wait_nmi_low(input string nm);
        int k;
        k = 0;
        while (nZ80NMI !== 1'b0 && k < 50) begin
            @(negedge CLK_24M);
            k++;
        end
        chk(nm, 32'(nZ80NMI), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] exp_pops [4];
        int p0;

        vt[0] = '{OP_ZWR,  8'h0C, 8'hC3, 8'h00, 3'd0, 1'b0, 8'hC3};
        vt[1] = '{OP_ZRD,  8'h0C, 8'h00, 8'hC3, 3'd0, 1'b0, 8'hC3};
        vt[2] = '{OP_PUSH, 8'h00, 8'h11, 8'h00, 3'd1, 1'b0, 8'hC3};
        vt[3] = '{OP_PUSH, 8'h00, 8'h12, 8'h00, 3'd2, 1'b0, 8'hC3};
        vt[4] = '{OP_PUSH, 8'h00, 8'h13, 8'h00, 3'd3, 1'b0, 8'hC3};
        vt[5] = '{OP_PUSH, 8'h00, 8'h14, 8'h00, 3'd4, 1'b1, 8'hC3};
        vt[6] = '{OP_PUSH, 8'h00, 8'h15, 8'h00, 3'd4, 1'b1, 8'hC3};
        vt[7] = '{OP_ZRD,  8'h08, 8'h00, 8'hA4, 3'd4, 1'b1, 8'hC3};
        vt[8] = '{OP_ZRD,  8'h08, 8'h00, 8'h24, 3'd4, 1'b1, 8'hC3};
        exp_pops = '{8'h12, 8'h13, 8'h14, 8'h16};

        nRESET = 1'b0;
        SDA_L = 8'h00; SDD_IN = 8'h00; CMD_DATA = 8'h00;
        nIORQ = 1'b1; nSDRD = 1'b1; nSDWR = 1'b1; CMD_WR = 1'b0;
        repeat (3) @(negedge CLK_24M);
        chk("reset_nmi", 32'(nZ80NMI), 32'd1);
        chk("reset_level", 32'(CMD_LEVEL), 32'd0);
        chk("reset_full", 32'(CMD_FULL), 32'd0);
        chk("reset_reply", 32'(REPLY), 32'h00);
        chk("reset_sdd_out", 32'(SDD_OUT), 32'h00);
        nRESET = 1'b1;
        repeat (4) @(negedge CLK_24M);

        // Basic NMI handshake.
        z80_wr(8'h18, 8'h00);
        @(negedge CLK_24M);
        CMD_WR = 1'b1;
        CMD_DATA = 8'h5A;
        @(negedge CLK_24M);
        CMD_WR = 1'b0;
        chk("nmi_1cyc_after_push", 32'(nZ80NMI), 32'd1);
        @(negedge CLK_24M);
        chk("nmi_2cyc_after_push", 32'(nZ80NMI), 32'd0);
        z80_rd(8'h00, rd);
        chk("pop_5a", 32'(rd), 32'h5A);
        chk("nmi_released_by_pop", 32'(nZ80NMI), 32'd1);
        chk("level_after_pop", 32'(CMD_LEVEL), 32'd0);
        repeat (10) @(negedge CLK_24M);

        // Three queued commands.
        p0 = pulses;
        push(8'h01); push(8'h02); push(8'h03);
`ifdef Z80CTRL_NMI_AUTOREARM_EN
        for (int i = 0; i < 3; i++) begin
            wait_nmi_low("autorearm_nmi_low");
            z80_rd(8'h00, rd);
            chk("autorearm_pop", 32'(rd), 32'(i + 1));
        end
        repeat (20) @(negedge CLK_24M);
        chk("autorearm_pulses", 32'(pulses - p0), 32'd3);
        chk("autorearm_gap2", 32'(gap_log[(p0 + 1) % 64]), 32'd6);
        chk("autorearm_gap3", 32'(gap_log[(p0 + 2) % 64]), 32'd6);
`else
        wait_nmi_low("legacy_nmi_low");
        for (int i = 0; i < 3; i++) begin
            z80_rd(8'h00, rd);
            chk("legacy_pop", 32'(rd), 32'(i + 1));
        end
        repeat (20) @(negedge CLK_24M);
        chk("legacy_pulses", 32'(pulses - p0), 32'd1);
`endif
        chk("level_after_three", 32'(CMD_LEVEL), 32'd0);

        // Disable NMI, then table of FIFO / status / reply vectors.
        z80_wr(8'h08, 8'h00);
        for (int i = 0; i < 9; i++) begin
            case (vt[i].op)
                OP_PUSH: push(vt[i].data);
                OP_ZRD:  begin
                    z80_rd(vt[i].addr, rd);
                    chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rd));
                end
                default: z80_wr(vt[i].addr, vt[i].data);
            endcase
            chk($sformatf("vec%0d_level", i), 32'(CMD_LEVEL), 32'(vt[i].exp_lvl));
            chk($sformatf("vec%0d_full", i), 32'(CMD_FULL), 32'(vt[i].exp_full));
            chk($sformatf("vec%0d_reply", i), 32'(REPLY), 32'(vt[i].exp_reply));
        end

        // Push and pop landing on the same edge while full.
        @(negedge CLK_24M);
        SDA_L = 8'h00;
        nIORQ = 1'b0;
        nSDRD = 1'b0;
        repeat (3) @(negedge CLK_24M);
        chk("pp_head", 32'(SDD_OUT), 32'h11);
        nIORQ = 1'b1;
        nSDRD = 1'b1;
        repeat (SYNC) @(negedge CLK_24M);
        CMD_WR = 1'b1;
        CMD_DATA = 8'h16;
        @(negedge CLK_24M);
        CMD_WR = 1'b0;
        chk("pp_level", 32'(CMD_LEVEL), 32'd4);
        chk("pp_full", 32'(CMD_FULL), 32'd1);
        z80_rd(8'h08, rd);
        chk("pp_status_no_ovf", 32'(rd), 32'h24);
        for (int i = 0; i < 4; i++) begin
            z80_rd(8'h00, rd);
            chk("pp_order", 32'(rd), 32'(exp_pops[i]));
            chk("pp_drain_level", 32'(CMD_LEVEL), 32'(3 - i));
        end
        z80_rd(8'h00, rd);
        chk("pop_empty_last", 32'(rd), 32'h16);
        chk("pop_empty_level", 32'(CMD_LEVEL), 32'd0);
        z80_rd(8'h08, rd);
        chk("status_empty", 32'(rd), 32'h40);

        // YM2610 strobes follow the raw decode and touch nothing else.
        @(negedge CLK_24M);
        SDA_L = 8'h04;
        SDD_IN = 8'h55;
        nIORQ = 1'b0;
        nSDWR = 1'b0;
        #1;
        chk("ym_wr_low", 32'(n2610WR), 32'd0);
        chk("ym_cs_low", 32'(n2610CS), 32'd0);
        chk("ym_rd_idle", 32'(n2610RD), 32'd1);
        repeat (3) @(negedge CLK_24M);
        nIORQ = 1'b1;
        nSDWR = 1'b1;
        #1;
        chk("ym_wr_high", 32'(n2610WR), 32'd1);
        chk("ym_cs_high", 32'(n2610CS), 32'd1);
        repeat (6) @(negedge CLK_24M);
        chk("ym_level", 32'(CMD_LEVEL), 32'd0);
        chk("ym_nmi", 32'(nZ80NMI), 32'd1);
        chk("ym_reply", 32'(REPLY), 32'hC3);
        @(negedge CLK_24M);
        nIORQ = 1'b0;
        nSDRD = 1'b0;
        #1;
        chk("ym_rd_low", 32'(n2610RD), 32'd0);
        @(negedge CLK_24M);
        nIORQ = 1'b1;
        nSDRD = 1'b1;
        repeat (6) @(negedge CLK_24M);

        // Reset in the middle of an NMI and a Z80 read.
        z80_wr(8'h18, 8'h00);
        push(8'hA1);
        push(8'hA2);
        wait_nmi_low("rst_nmi_low");
        @(negedge CLK_24M);
        SDA_L = 8'h00;
        nIORQ = 1'b0;
        nSDRD = 1'b0;
        repeat (3) @(negedge CLK_24M);
        nRESET = 1'b0;
        #1;
        chk("rst_nmi", 32'(nZ80NMI), 32'd1);
        chk("rst_level", 32'(CMD_LEVEL), 32'd0);
        chk("rst_reply", 32'(REPLY), 32'h00);
        repeat (2) @(negedge CLK_24M);
        nRESET = 1'b1;
        push(8'h77);
        repeat (3) @(negedge CLK_24M);
        nIORQ = 1'b1;
        nSDRD = 1'b1;
        repeat (8) @(negedge CLK_24M);
        chk("rst_stale_edge_ignored", 32'(CMD_LEVEL), 32'd1);
        chk("rst_enable_cleared", 32'(nZ80NMI), 32'd1);
        z80_rd(8'h00, rd);
        chk("rst_pop_77", 32'(rd), 32'h77);
        chk("rst_final_level", 32'(CMD_LEVEL), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
